// File: rtl/audio_oscillator_multi_if.sv
// AXI-Stream style sample bus between the oscillator and its downstream filter chain.
interface audio_oscillator_multi_if #(
    parameter int SAMPLE_SIZE = 16
);
    logic                   tvalid;
    logic                   tready;
    logic [SAMPLE_SIZE-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/audio_oscillator_multi.sv
// Phase-accumulator oscillator (saw/triangle/pulse/noise) with double-buffered config
// that only switches at a period wrap or an explicit sync.
module audio_oscillator_multi #(
    parameter int SAMPLE_SIZE = 16,
    parameter int PHASE_WIDTH = 32,
    parameter int DUTY_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [PHASE_WIDTH-1:0] divisor,
    input  logic [DUTY_WIDTH-1:0]  duty,
    input  logic [1:0]             waveform,
    input  logic                   sync,
    output logic                   sync_out,
    audio_oscillator_multi_if.master axis
);
    localparam int S = SAMPLE_SIZE;
    localparam int M = PHASE_WIDTH;
    localparam int D = DUTY_WIDTH;
    localparam logic [31:0] LFSR_MASK = 32'h80200003;
    localparam logic [31:0] LFSR_SEED = 32'h00000001;

    generate
        if (SAMPLE_SIZE < 2 || SAMPLE_SIZE > 32) begin : g_bad_sample_size
            $error("audio_oscillator_multi: SAMPLE_SIZE must be within 2..32");
        end
        if (PHASE_WIDTH < SAMPLE_SIZE + 1) begin : g_bad_phase_width
            $error("audio_oscillator_multi: PHASE_WIDTH must be at least SAMPLE_SIZE+1");
        end
        if (DUTY_WIDTH < 1 || DUTY_WIDTH > PHASE_WIDTH) begin : g_bad_duty_width
            $error("audio_oscillator_multi: DUTY_WIDTH must be within 1..PHASE_WIDTH");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Waveform shaping; phase 0 maps to the most negative sample for saw and triangle.
    function automatic logic [S-1:0] wave_f(
        input logic [M-1:0] p,
        input logic [31:0]  l,
        input logic [1:0]   wf,
        input logic [D-1:0] dt
    );
        logic [S-1:0] fold;
        logic [S-1:0] res;
        fold = p[M-1] ? ~p[M-2 -: S] : p[M-2 -: S];
        case (wf)
            2'd0:    res = {~p[M-1], p[M-2 -: S-1]};
            2'd1:    res = {~fold[S-1], fold[S-2:0]};
            2'd2:    res = (p[M-1 -: D] < dt) ? {1'b0, {(S-1){1'b1}}} : {1'b1, {(S-1){1'b0}}};
            2'd3:    res = l[31 -: S];
            default: res = {S{1'b0}};
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lfsr_step_f(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_MASK) : (l >> 1);
    endfunction

    state_e         state_q, state_d;
    logic [M-1:0]   phase_q, phase_d;
    logic [31:0]    lfsr_q, lfsr_d;
    logic [M-1:0]   div_q, div_d;
    logic [D-1:0]   duty_q, duty_d;
    logic [1:0]     wave_q, wave_d;
    logic           pend_q, pend_d;
    logic [S-1:0]   tdata_q, tdata_d;
    logic           sync_out_q, sync_out_d;

    logic           txn_s;
    logic           pend_eff_s;
    logic           carry_s;
    logic [M-1:0]   sum_s;

    assign txn_s      = (state_q == ST_RUN) && axis.tready;
    // A sync arriving together with a transaction takes effect in that same transaction.
    assign pend_eff_s = pend_q | sync;
    assign {carry_s, sum_s} = {1'b0, phase_q} + {1'b0, div_q};

    // Next-state logic: first-edge config load, then per-transaction phase/noise advance.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        lfsr_d     = lfsr_q;
        div_d      = div_q;
        duty_d     = duty_q;
        wave_d     = wave_q;
        pend_d     = pend_q;
        tdata_d    = tdata_q;
        sync_out_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
                div_d   = divisor;
                duty_d  = duty;
                wave_d  = waveform;
                pend_d  = sync;
                tdata_d = wave_f(phase_q, lfsr_q, waveform, duty);
            end
            ST_RUN: begin
                if (txn_s) begin
                    phase_d = pend_eff_s ? {M{1'b0}} : sum_s;
                    lfsr_d  = lfsr_step_f(lfsr_q);
                    if (carry_s || pend_eff_s) begin
                        div_d      = divisor;
                        duty_d     = duty;
                        wave_d     = waveform;
                        pend_d     = 1'b0;
                        sync_out_d = 1'b1;
                    end else begin
                        pend_d     = 1'b0;
                    end
                    tdata_d = wave_f(phase_d, lfsr_d, wave_d, duty_d);
                end else begin
                    pend_d = pend_eff_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            phase_q    <= {M{1'b0}};
            lfsr_q     <= LFSR_SEED;
            div_q      <= {M{1'b0}};
            duty_q     <= {D{1'b0}};
            wave_q     <= 2'd0;
            pend_q     <= 1'b0;
            tdata_q    <= {S{1'b0}};
            sync_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            lfsr_q     <= lfsr_d;
            div_q      <= div_d;
            duty_q     <= duty_d;
            wave_q     <= wave_d;
            pend_q     <= pend_d;
            tdata_q    <= tdata_d;
            sync_out_q <= sync_out_d;
        end
    end

    assign axis.tvalid = (state_q == ST_RUN);
    assign axis.tdata  = tdata_q;
    assign sync_out    = sync_out_q;
endmodule
